// File: rtl/scv_pkg.sv
// scv_pkg: shared types and constants for the SCV core and its cartridge configuration sequencer.
// The cartridge sequencer's optional CRC feature is controlled by the SCV_CART_CRC_EN macro.
package scv_pkg;

  // Cartridge mapper selection; MAP_AUTO asks the sequencer to choose from the image size
  typedef enum logic [3:0] {
    MAP_AUTO        = 4'd0,
    MAP_ROM8K       = 4'd1,
    MAP_ROM16K      = 4'd2,
    MAP_ROM32K      = 4'd3,
    MAP_ROM32K_RAM  = 4'd4,
    MAP_ROM64K      = 4'd5,
    MAP_ROM128K     = 4'd6,
    MAP_ROM128K_RAM = 4'd7
  } mapper_t;

  // Cartridge configuration sequencer states; IDLE is never entered after reset
  typedef enum logic [2:0] {
    CC_IDLE    = 3'd0,
    CC_LOAD    = 3'd1,
    CC_RESOLVE = 3'd2,
    CC_HOLD    = 3'd3,
    CC_RUN     = 3'd4
  } cart_cfg_state_t;

  // Upper size bounds (inclusive) for each ROM-only mapper
  localparam int CART_SZ_8K  = 8192;
  localparam int CART_SZ_16K = 16384;
  localparam int CART_SZ_32K = 32768;
  localparam int CART_SZ_64K = 65536;

  // Picks the smallest ROM-only mapper that covers an image of n bytes; empty images get rom8k
  function automatic mapper_t mapper_from_size(input logic [31:0] n);
    mapper_t m;
    if (n <= 32'(CART_SZ_8K))       m = MAP_ROM8K;
    else if (n <= 32'(CART_SZ_16K)) m = MAP_ROM16K;
    else if (n <= 32'(CART_SZ_32K)) m = MAP_ROM32K;
    else if (n <= 32'(CART_SZ_64K)) m = MAP_ROM64K;
    else                            m = MAP_ROM128K;
    return m;
  endfunction

endpackage

// File: rtl/scv_crc16.sv
// scv_crc16: byte-serial CRC-16/CCITT (poly 0x1021, init 0xFFFF), one byte per clock.
// Only instantiated when the SCV_CART_CRC_EN macro is defined.
module scv_crc16 (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        clear,
  input  logic        valid,
  input  logic [7:0]  data,
  output logic [15:0] crc
);

  // Folds one byte into the running CRC, MSB first, no reflection
  function automatic logic [15:0] crc_byte(input logic [15:0] c, input logic [7:0] d);
    logic [15:0] r;
    r = c ^ {d, 8'h00};
    for (int i = 0; i < 8; i++) begin
      r = r[15] ? ((r << 1) ^ 16'h1021) : (r << 1);
    end
    return r;
  endfunction

  // Running CRC: reinitialised while clear is high, advanced on each accepted byte
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      crc <= 16'hFFFF;
    end else if (clear) begin
      crc <= 16'hFFFF;
    end else if (valid) begin
      crc <= crc_byte(crc, data);
    end
  end

endmodule

// File: rtl/scv_cart_cfg.sv
// scv_cart_cfg: measures downloaded cartridge images, resolves the mapper and
// sequences a stretched core reset so the core only runs on a stable image and mapper.
// Optional image CRC (CART_CRC / ROMINIT_DATA) is built when SCV_CART_CRC_EN is defined.
module scv_cart_cfg
  import scv_pkg::*;
#(
  parameter int HOLD_CYCLES = 1024,
  parameter int SIZE_W      = 18
) (
  input  logic              CLK,
  input  logic              RESB,
  input  logic              ROMINIT_ACTIVE,
  input  logic              ROMINIT_SEL_CART,
  input  logic [16:0]       ROMINIT_ADDR,
  input  logic              ROMINIT_VALID,
  input  logic [3:0]        MAPPER_REQ,
  input  logic              USER_RST,
`ifdef SCV_CART_CRC_EN
  input  logic [7:0]        ROMINIT_DATA,
  output logic [15:0]       CART_CRC,
`endif
  output logic [3:0]        MAPPER,
  output logic [SIZE_W-1:0] CART_SIZE,
  output logic              CART_LOADED,
  output logic              SYS_RESB
);

  localparam int CNT_W = $clog2(HOLD_CYCLES + 1);

  cart_cfg_state_t   state;
  logic [CNT_W-1:0]  hold_cnt;
  logic [SIZE_W-1:0] size_acc;
  logic [3:0]        req_latched;
  logic [SIZE_W-1:0] addr_next;
  logic [SIZE_W-1:0] resolved_size;
  logic [3:0]        resolved_map;
  logic              cart_write;

  // Widen before the +1 so the top address 0x1FFFF yields 131072 instead of wrapping
  assign addr_next  = SIZE_W'(ROMINIT_ADDR) + SIZE_W'(1);
  assign cart_write = (state == CC_LOAD) && ROMINIT_VALID && ROMINIT_SEL_CART;

  // Size and mapper the RESOLVE step will commit; an empty download keeps the previous image size
  always_comb begin
    resolved_size = (size_acc != '0) ? size_acc : CART_SIZE;
    resolved_map  = (MAPPER_REQ != 4'd0) ? MAPPER_REQ : 4'(mapper_from_size(32'(resolved_size)));
  end

  // Sequencer FSM with registered outputs; the core reset is only released while staying in RUN
  always_ff @(posedge CLK or negedge RESB) begin
    if (!RESB) begin
      state       <= CC_HOLD;
      hold_cnt    <= '0;
      size_acc    <= '0;
      req_latched <= 4'd0;
      MAPPER      <= 4'(MAP_ROM8K);
      CART_SIZE   <= '0;
      CART_LOADED <= 1'b0;
      SYS_RESB    <= 1'b0;
    end else begin
      case (state)
        CC_HOLD: begin
          SYS_RESB <= 1'b0;
          if (ROMINIT_ACTIVE) begin
            state    <= CC_LOAD;
            size_acc <= '0;
          end else if (USER_RST) begin
            hold_cnt <= '0;
          end else if (hold_cnt == CNT_W'(HOLD_CYCLES - 1)) begin
            state <= CC_RUN;
          end else begin
            hold_cnt <= hold_cnt + 1'b1;
          end
        end
        CC_RUN: begin
          if (ROMINIT_ACTIVE) begin
            state    <= CC_LOAD;
            size_acc <= '0;
            SYS_RESB <= 1'b0;
          end else if (USER_RST) begin
            state    <= CC_HOLD;
            hold_cnt <= '0;
            SYS_RESB <= 1'b0;
          end else if (MAPPER_REQ != req_latched) begin
            state    <= CC_RESOLVE;
            SYS_RESB <= 1'b0;
          end else begin
            SYS_RESB <= 1'b1;
          end
        end
        CC_LOAD: begin
          SYS_RESB <= 1'b0;
          if (cart_write && (addr_next > size_acc)) begin
            size_acc <= addr_next;
          end
          if (!ROMINIT_ACTIVE) begin
            state <= CC_RESOLVE;
          end
        end
        CC_RESOLVE: begin
          SYS_RESB <= 1'b0;
          if (size_acc != '0) begin
            CART_SIZE   <= size_acc;
            CART_LOADED <= 1'b1;
          end
          req_latched <= MAPPER_REQ;
          MAPPER      <= resolved_map;
          state       <= CC_HOLD;
          hold_cnt    <= '0;
        end
        default: begin
          SYS_RESB <= 1'b0;
          state    <= CC_HOLD;
          hold_cnt <= '0;
        end
      endcase
    end
  end

`ifdef SCV_CART_CRC_EN
  logic [15:0] crc_run;

  scv_crc16 u_crc (
    .clk   (CLK),
    .rst_n (RESB),
    .clear (state != CC_LOAD),
    .valid (cart_write),
    .data  (ROMINIT_DATA),
    .crc   (crc_run)
  );

  // Publish the image CRC together with the image size, only for non-empty cart downloads
  always_ff @(posedge CLK or negedge RESB) begin
    if (!RESB) begin
      CART_CRC <= 16'hFFFF;
    end else if ((state == CC_RESOLVE) && (size_acc != '0)) begin
      CART_CRC <= crc_run;
    end
  end
`endif

endmodule
